// File: rtl/ds18b20_ctrl.sv
// ds18b20_ctrl: 1-Wire master polling a single DS18B20 sensor.
// Loops forever: write config, start conversion, read temperature.
module ds18b20_ctrl #(
  parameter int CLK_PER_US  = 50,
  parameter int CONV_US_12B = 750000,
  parameter int RETRY_US    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  res_sel,
  input  logic        dq_i,
  output logic        dq_oe,
  output logic [15:0] temp_data,
  output logic [1:0]  ratio,
  output logic        temp_vld,
  output logic        presence_err
);

  typedef enum logic [3:0] {
    INIT, RST_LOW, RST_PRES, RST_REC, CMD,
    WR_SLOT, RD_SLOT, CONV_WAIT, DONE, RETRY
  } state_t;

  localparam logic [19:0] CONV20  = 20'(CONV_US_12B);
  localparam logic [19:0] RETRY20 = 20'(RETRY_US);

  state_t      state, state_nx;
  logic        dq_m, dq_s;
  logic [15:0] pre;
  logic [19:0] us, lim, conv_us;
  logic        tick, fin, clr;
  logic [1:0]  phase, res_q;
  logic [2:0]  bidx, nbytes;
  logic [3:0]  bitn;
  logic [7:0]  cur_byte, cfg;
  logic        wr_bit;
  logic [15:0] rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_m <= 1'b1;
      dq_s <= 1'b1;
    end else begin
      dq_m <= dq_i;
      dq_s <= dq_m;
    end
  end

  assign tick = (pre == 16'(CLK_PER_US - 1));
  assign fin  = tick && (us == lim - 20'd1);
  // presence sample and recovery share one timebase from release
  assign clr  = (state_nx != state) &&
                !(state == RST_PRES && state_nx == RST_REC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      us  <= '0;
    end else if (clr) begin
      pre <= '0;
      us  <= '0;
    end else if (tick) begin
      pre <= '0;
      us  <= us + 20'd1;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  always_comb begin
    unique case (res_q)
      2'd1:    conv_us = CONV20 >> 3;
      2'd2:    conv_us = CONV20 >> 2;
      2'd3:    conv_us = CONV20 >> 1;
      default: conv_us = CONV20;
    endcase
  end

  always_comb begin
    unique case (state)
      RST_LOW, RST_REC: lim = 20'd480;
      RST_PRES:         lim = 20'd70;
      WR_SLOT, RD_SLOT: lim = 20'd62;
      CONV_WAIT:        lim = conv_us;
      RETRY:            lim = RETRY20;
      default:          lim = 20'd1;
    endcase
  end

  assign cfg    = {1'b0, res_q - 2'd1, 5'b11111};
  assign nbytes = (phase == 2'd0) ? 3'd5 : 3'd2;

  always_comb begin
    unique case (bidx)
      3'd1: begin
        unique case (phase)
          2'd0:    cur_byte = 8'h4E;
          2'd1:    cur_byte = 8'h44;
          default: cur_byte = 8'hBE;
        endcase
      end
      3'd2:    cur_byte = 8'h7F;
      3'd3:    cur_byte = 8'h80;
      3'd4:    cur_byte = cfg;
      default: cur_byte = 8'hCC;
    endcase
  end

  assign wr_bit = cur_byte[bitn[2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT:     state_nx = RST_LOW;
      RST_LOW:  if (fin) state_nx = RST_PRES;
      RST_PRES: if (fin) state_nx = dq_s ? RETRY : RST_REC;
      RST_REC:  if (fin) state_nx = CMD;
      CMD: begin
        if (bidx != nbytes) state_nx = WR_SLOT;
        else begin
          unique case (phase)
            2'd0:    state_nx = INIT;
            2'd1:    state_nx = CONV_WAIT;
            default: state_nx = RD_SLOT;
          endcase
        end
      end
      WR_SLOT:   if (fin) state_nx = CMD;
      RD_SLOT:   if (fin) state_nx = (bitn == 4'd15) ? DONE : CMD;
      CONV_WAIT: if (fin) state_nx = INIT;
      DONE:      state_nx = INIT;
      RETRY:     if (fin) state_nx = INIT;
      default:   state_nx = INIT;
    endcase
  end

  always_comb begin
    dq_oe    = 1'b0;
    temp_vld = 1'b0;
    unique case (state)
      RST_LOW: dq_oe = 1'b1;
      WR_SLOT: dq_oe = us < (wr_bit ? 20'd2 : 20'd60);
      RD_SLOT: dq_oe = us < 20'd2;
      DONE:    temp_vld = 1'b1;
      default: dq_oe = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= '0;
      res_q        <= '0;
      bidx         <= '0;
      bitn         <= '0;
      rd           <= '0;
      temp_data    <= '0;
      ratio        <= '0;
      presence_err <= 1'b0;
    end else begin
      if (state == INIT) begin
        bidx <= '0;
        bitn <= '0;
        if (phase == 2'd0) res_q <= res_sel;
      end
      if (state == RST_PRES && fin) presence_err <= dq_s;
      if (state == RETRY && fin) phase <= 2'd0;
      if (state == CMD && bidx == nbytes && phase == 2'd0)
        phase <= 2'd1;
      if (state == CONV_WAIT && fin) phase <= 2'd2;
      if (state == DONE) phase <= 2'd0;
      if (state == WR_SLOT && fin) begin
        bitn <= {1'b0, bitn[2:0] + 3'd1};
        if (bitn[2:0] == 3'd7) bidx <= bidx + 3'd1;
      end
      if (state == RD_SLOT) begin
        if (tick && us == 20'd11) rd <= {dq_s, rd[15:1]};
        if (fin) bitn <= bitn + 4'd1;
        if (fin && bitn == 4'd15) begin
          temp_data <= rd;
          ratio     <= res_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_ctrl.sv
// tb_ds18b20_ctrl: DS18B20 bus model plus scoreboard
// for written bytes and reported temperatures.
`timescale 1ns/1ps
module tb_ds18b20_ctrl;

  localparam int  CPU   = 4;
  localparam int  CONV  = 1000;
  localparam int  RETRY = 100;
  localparam time CLK   = 10;
  localparam time US    = CLK * CPU;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  res_sel;
  logic        dq_i;
  logic        dq_oe;
  logic [15:0] temp_data;
  logic [1:0]  ratio;
  logic        temp_vld;
  logic        presence_err;

  bit          present = 1'b0;
  logic        dev_pull = 1'b0;
  logic [15:0] bfm_temp = 16'h0191;

  int  checks = 0;
  int  passes = 0;
  int  bytes_seen = 0;
  int  vld_seen = 0;
  int  rises = 0;
  time last_rise = 0;
  time prev_rise = 0;

  logic [7:0]  exp_b[$];
  logic [17:0] exp_t[$];

  assign dq_i = ~(dq_oe | dev_pull);

  always #(CLK / 2) clk = ~clk;

  ds18b20_ctrl #(
    .CLK_PER_US (CPU),
    .CONV_US_12B(CONV),
    .RETRY_US   (RETRY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_sel     (res_sel),
    .dq_i        (dq_i),
    .dq_oe       (dq_oe),
    .temp_data   (temp_data),
    .ratio       (ratio),
    .temp_vld    (temp_vld),
    .presence_err(presence_err)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic push_round(input logic [7:0] cfg,
                            input logic [1:0] r,
                            input logic [15:0] t);
    exp_b.push_back(8'hCC);
    exp_b.push_back(8'h4E);
    exp_b.push_back(8'h7F);
    exp_b.push_back(8'h80);
    exp_b.push_back(cfg);
    exp_b.push_back(8'hCC);
    exp_b.push_back(8'h44);
    exp_b.push_back(8'hCC);
    exp_b.push_back(8'hBE);
    exp_t.push_back({r, t});
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0:       return bytes_seen;
      1:       return vld_seen;
      default: return rises;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int target,
                          input int max_clk, input string name);
    int n = 0;
    while (cnt_of(which) < target && n < max_clk) begin
      @(posedge clk); #1; n++;
    end
    if (cnt_of(which) < target) timeout(name);
  endtask

  task automatic wait_oe(input logic v, input int max_clk,
                         output time t);
    int n = 0;
    while (dq_oe !== v && n < max_clk) begin
      @(posedge clk); #1; n++;
    end
    t = $time;
    if (dq_oe !== v) timeout("wait_dq_oe");
  endtask

  task automatic wait_pe(input logic v, input int max_clk,
                         output time t);
    int n = 0;
    while (presence_err !== v && n < max_clk) begin
      @(posedge clk); #1; n++;
    end
    t = $time;
    if (presence_err !== v) timeout("wait_presence_err");
  endtask

  // Device model: presence pulse, write decode, read replies
  initial begin : bfm
    logic [7:0] sh;
    int  bcnt;
    bit  rd_mode;
    int  rd_idx;
    time t0, dt;
    sh = '0; bcnt = 0; rd_mode = 0; rd_idx = 0;
    forever begin
      @(posedge dq_oe);
      prev_rise = last_rise;
      last_rise = $time;
      rises++;
      if (rd_mode) begin
        dev_pull = present && !bfm_temp[rd_idx];
        rd_idx++;
        if (rd_idx == 16) rd_mode = 0;
        #(30 * US);
        dev_pull = 1'b0;
      end else begin
        t0 = $time;
        @(negedge dq_oe);
        dt = $time - t0;
        if (!rst_n) begin
          bcnt = 0;
          sh = '0;
        end else if (dt > 200 * US) begin
          bcnt = 0;
          rd_mode = 0;
          if (present) begin
            #(15 * US);
            dev_pull = 1'b1;
            #(120 * US);
            dev_pull = 1'b0;
          end
        end else begin
          sh = {dt < 15 * US, sh[7:1]};
          bcnt++;
          if (bcnt == 8) begin
            bcnt = 0;
            bytes_seen++;
            if (exp_b.size() == 0) timeout("byte_unexpected");
            else chk("wr_byte", sh, exp_b.pop_front());
            if (sh == 8'hBE) begin
              rd_mode = 1;
              rd_idx = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && temp_vld) begin
      logic [17:0] e;
      vld_seen++;
      if (exp_t.size() == 0) timeout("temp_unexpected");
      else begin
        e = exp_t.pop_front();
        chk("temp_data", temp_data, e[15:0]);
        chk("ratio", ratio, e[17:16]);
      end
      @(negedge clk);
      chk("vld_pulse", temp_vld, 0);
    end
  end

  initial begin
    time t0, t1, t2, t3, t4, t5;
    int  n;
    rst_n = 1'b0;
    res_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_temp_data", temp_data, 0);
    chk("rst_ratio", ratio, 0);
    chk("rst_temp_vld", temp_vld, 0);
    chk("rst_presence_err", presence_err, 0);
    rst_n = 1'b1;

    wait_oe(1'b1, 10, t0);
    wait_oe(1'b0, 480 * CPU + 20, t1);
    chk("reset_low_time", t1 - t0, 480 * US);
    wait_pe(1'b1, 80 * CPU, t2);
    chk("presence_sample_time", t2 - t1, 70 * US);
    wait_oe(1'b1, (RETRY + 10) * CPU, t3);
    chk("retry_gap", t3 - t2, RETRY * US + CLK);

    present = 1'b1;
    wait_pe(1'b0, 560 * CPU, t4);
    chk("presence_clear_time", t4 - t3, 550 * US);
    wait_oe(1'b1, 500 * CPU, t5);
    chk("first_slot_time", t5 - t3, 960 * US + CLK);

    #(30 * US);
    chk("slot_low", dq_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("async_release", dq_oe, 0);
    chk("async_presence_err", presence_err, 0);
    chk("async_temp_vld", temp_vld, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    push_round(8'h7F, 2'd0, 16'h0191);
    wait_cnt(0, 7, 20000 * CPU, "round_a_convert_cmd");
    n = rises;
    res_sel = 2'd1;
    wait_cnt(2, n + 1, (CONV + 200) * CPU, "conv_end_12b");
    chk("conv_wait_12b", last_rise - prev_rise,
        (62 + CONV) * US + 2 * CLK);
    wait_cnt(1, 1, 8000 * CPU, "round_a_temp");

    bfm_temp = 16'hFF5E;
    push_round(8'h1F, 2'd1, 16'hFF5E);
    wait_cnt(0, 16, 12000 * CPU, "round_b_convert_cmd");
    n = rises;
    wait_cnt(2, n + 1, 400 * CPU, "conv_end_9b");
    chk("conv_wait_9b", last_rise - prev_rise,
        (62 + CONV / 8) * US + 2 * CLK);
    wait_cnt(1, 2, 8000 * CPU, "round_b_temp");

    repeat (3) @(posedge clk);
    #1;
    chk("final_presence_err", presence_err, 0);
    chk("bytes_left", exp_b.size(), 0);
    chk("temps_left", exp_t.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
